// File: rtl/cart_eeprom_ctrl.sv
// Microwire (93C46-class, x16) EEPROM controller for cartridge save memory.
// Decodes the C4h..C8h register window and sequences select/header/data/
// deselect/ready-poll frames on the EEPROM pins.
module cart_eeprom_ctrl #(
    parameter int CLK_DIV     = 4,
    parameter int ADDR_W      = 6,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic [7:0] ADDR,
    input  logic       WR,
    input  logic [7:0] WDATA,
    output logic [7:0] RDATA,
    output logic       EECS,
    output logic       EESK,
    output logic       EEDI,
    input  logic       EEDO
);
    localparam int HDR_W = 3 + ADDR_W;
    localparam int CW    = $clog2(2*CLK_DIV + 1);
    localparam int BW    = $clog2((HDR_W > 16) ? HDR_W : 16);
    localparam int TW    = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, SELECT, HDR, DOUT, DIN, DESEL, POLL} state_t;

    // frame latched on an accepted GO
    typedef struct packed {
        logic [1:0]        op;
        logic [ADDR_W-1:0] addr;
    } frame_t;

    state_t            state, state_d;
    frame_t            fr_q;
    logic [CW-1:0]     cnt, cnt_d;
    logic [BW-1:0]     bidx, bidx_d;
    logic [TW-1:0]     pcnt, pcnt_d;
    logic [15:0]       data_q;
    logic [ADDR_W-1:0] waddr_q;
    logic              done_q, tmo_q;
    logic              start, fin_ok, fin_tmo, shift_in;

    wire       sel_cmd  = WR && (ADDR == 8'hC8);
    wire       go       = sel_cmd && WDATA[7];
    wire       abort    = sel_cmd && WDATA[6];
    wire       busy     = (state != IDLE);
    wire       cell_end = (cnt == CW'(2*CLK_DIV - 1));
    wire [1:0] sub      = fr_q.addr[ADDR_W-1 -: 2];
    wire       ext      = (fr_q.op == 2'b00);
    wire       has_dout = (fr_q.op == 2'b01) || (ext && sub == 2'b01);
    wire       has_din  = (fr_q.op == 2'b10);
    wire       has_poll = (fr_q.op == 2'b01) || (fr_q.op == 2'b11) ||
                          (ext && (sub == 2'b01 || sub == 2'b10));
    wire [HDR_W-1:0] hdr_bits = {1'b1, fr_q.op, fr_q.addr};
    wire       unused_wdata = ^WDATA[5:2];

    // state register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
            cnt   <= '0;
            bidx  <= '0;
            pcnt  <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            bidx  <= bidx_d;
            pcnt  <= pcnt_d;
        end
    end

    // next-state: bit-cell timing, frame sequencing, poll exit, abort override
    always_comb begin
        state_d  = state;
        cnt_d    = cnt + CW'(1);
        bidx_d   = bidx;
        pcnt_d   = pcnt;
        start    = 1'b0;
        fin_ok   = 1'b0;
        fin_tmo  = 1'b0;
        shift_in = 1'b0;
        case (state)
            IDLE: begin
                cnt_d = '0;
                if (go) begin
                    state_d = SELECT;
                    start   = 1'b1;
                end
            end
            SELECT: if (cnt == CW'(CLK_DIV - 1)) begin
                state_d = HDR;
                cnt_d   = '0;
                bidx_d  = BW'(HDR_W - 1);
            end
            HDR: if (cell_end) begin
                cnt_d = '0;
                if (bidx != '0) bidx_d = bidx - BW'(1);
                else begin
                    bidx_d = BW'(15);
                    if (has_dout)     state_d = DOUT;
                    else if (has_din) state_d = DIN;
                    else              state_d = DESEL;
                end
            end
            DOUT: if (cell_end) begin
                cnt_d = '0;
                if (bidx != '0) bidx_d = bidx - BW'(1);
                else            state_d = DESEL;
            end
            DIN: if (cell_end) begin
                cnt_d    = '0;
                shift_in = 1'b1;
                if (bidx != '0) bidx_d = bidx - BW'(1);
                else            state_d = DESEL;
            end
            DESEL: if (cell_end) begin
                cnt_d = '0;
                if (has_poll) begin
                    state_d = POLL;
                    pcnt_d  = '0;
                end else begin
                    state_d = IDLE;
                    fin_ok  = 1'b1;
                end
            end
            POLL: begin
                cnt_d = '0;
                if (EEDO) begin
                    state_d = IDLE;
                    fin_ok  = 1'b1;
                end else if (pcnt == TW'(TIMEOUT_CYC - 1)) begin
                    state_d = IDLE;
                    fin_tmo = 1'b1;
                end else begin
                    pcnt_d = pcnt + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        if (abort && busy) begin
            state_d  = IDLE;
            cnt_d    = '0;
            fin_ok   = 1'b0;
            fin_tmo  = 1'b0;
            shift_in = 1'b0;
        end
    end

    // status flags and frame latch
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            done_q <= 1'b0;
            tmo_q  <= 1'b0;
            fr_q   <= '0;
        end else begin
            if (start) begin
                done_q <= 1'b0;
                tmo_q  <= 1'b0;
                fr_q   <= '{op: WDATA[1:0], addr: waddr_q};
            end
            if (abort && busy) done_q <= 1'b0;
            if (fin_ok)        done_q <= 1'b1;
            if (fin_tmo)       tmo_q  <= 1'b1;
        end
    end

    // data/address registers: host writes only while idle, DIN shifts MSB first
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            data_q  <= '0;
            waddr_q <= '0;
        end else if (shift_in) begin
            data_q <= {data_q[14:0], EEDO};
        end else if (WR && !busy) begin
            case (ADDR)
                8'hC4:   data_q[7:0]  <= WDATA;
                8'hC5:   data_q[15:8] <= WDATA;
                8'hC6:   waddr_q      <= WDATA[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    // pin decode: SK low then high within each cell, DI held for the whole cell
    always_comb begin
        EECS = (state == SELECT) || (state == HDR) || (state == DOUT) ||
               (state == DIN) || (state == POLL);
        EESK = ((state == HDR) || (state == DOUT) || (state == DIN)) &&
               (cnt >= CW'(CLK_DIV));
        EEDI = 1'b0;
        if (state == HDR)       EEDI = hdr_bits[bidx];
        else if (state == DOUT) EEDI = data_q[bidx];
    end

    // register read mux
    always_comb begin
        case (ADDR)
            8'hC4:   RDATA = data_q[7:0];
            8'hC5:   RDATA = data_q[15:8];
            8'hC6:   RDATA = 8'(waddr_q);
            8'hC8:   RDATA = {5'b0, tmo_q, done_q, busy};
            default: RDATA = 8'hFF;
        endcase
    end
endmodule
